// File: rtl/mem_trace_serializer.sv
// Serializes memory-request records into a framed, little-endian byte trace stream.
// Define MEMTRACE_CHECKSUM_EN to append an XOR checksum byte to every record.
module mem_trace_serializer #(
  parameter int unsigned ADDR_BYTES = 4,
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_store,
  input  logic [1:0]              req_size,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_data,
  output logic                    trace_write_valid,
  input  logic                    trace_write_ready,
  output logic [7:0]              trace_write_bits,
  output logic [15:0]             record_count
);

  localparam int unsigned MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);

`ifdef MEMTRACE_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, ADDR, DATA, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_t;
`endif

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d, idx_inc, data_last;
  logic                            valid_q, valid_d;
  logic [7:0]                      bits_q, bits_d;
  logic [15:0]                     count_q, count_d;
  logic [3:0]                      seq_q, seq_d;
  logic                            ready_q, ready_d;
  logic                            is_store_q;
  logic [1:0]                      size_q;
  logic [ADDR_BYTES-1:0][7:0]      addr_q;
  logic [DATA_BYTES-1:0][7:0]      data_q;
  logic                            accept_c;
  logic                            hs;
  logic                            tail;
  logic                            done;
  int unsigned                     data_n;
`ifdef MEMTRACE_CHECKSUM_EN
  logic [7:0]                      csum_q, csum_d;
`endif

  assign accept_c = (state_q == IDLE) && req_valid && ready_q;
  assign hs       = valid_q && trace_write_ready;
  assign idx_inc  = idx_q + IDX_W'(1);

  // Store data length: 2^size bytes, clamped to the data bus width.
  always_comb begin
    data_n = 32'd1 << size_q;
    if (data_n > DATA_BYTES) data_n = DATA_BYTES;
    data_last = IDX_W'(data_n - 32'd1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    bits_d  = bits_q;
    count_d = count_q;
    seq_d   = seq_q;
    tail    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = HDR;
          valid_d = 1'b1;
          bits_d  = {1'b1, req_is_store, req_size, seq_q};
          seq_d   = seq_q + 4'd1;
        end
      end
      HDR: begin
        if (hs) begin
          state_d = ADDR;
          idx_d   = '0;
          bits_d  = addr_q[0];
        end
      end
      ADDR: begin
        if (hs) begin
          if (idx_q != ADDR_LAST) begin
            idx_d  = idx_inc;
            bits_d = addr_q[idx_inc];
          end else if (is_store_q) begin
            state_d = DATA;
            idx_d   = '0;
            bits_d  = data_q[0];
          end else begin
            tail = 1'b1;
          end
        end
      end
      DATA: begin
        if (hs) begin
          if (idx_q != data_last) begin
            idx_d  = idx_inc;
            bits_d = data_q[idx_inc];
          end else begin
            tail = 1'b1;
          end
        end
      end
`ifdef MEMTRACE_CHECKSUM_EN
      CSUM: begin
        if (hs) done = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Last payload byte accepted: either append the checksum or close the record.
    if (tail) begin
`ifdef MEMTRACE_CHECKSUM_EN
      state_d = CSUM;
      idx_d   = '0;
      bits_d  = csum_q;
`else
      done = 1'b1;
`endif
    end

    if (done) begin
      state_d = IDLE;
      valid_d = 1'b0;
      count_d = count_q + 16'd1;
    end

    ready_d = (state_d == IDLE);
  end

`ifdef MEMTRACE_CHECKSUM_EN
  // Running XOR of every byte loaded for this record, header included.
  always_comb begin
    csum_d = csum_q;
    if (accept_c) begin
      csum_d = bits_d;
    end else if (hs && state_d != IDLE && state_d != CSUM) begin
      csum_d = csum_q ^ bits_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      bits_q  <= 8'h00;
      count_q <= 16'd0;
      seq_q   <= 4'd0;
      ready_q <= 1'b0;
`ifdef MEMTRACE_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      bits_q  <= bits_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      ready_q <= ready_d;
`ifdef MEMTRACE_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Record buffer: written only on acceptance, stable for the whole emission.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_store_q <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (accept_c) begin
      is_store_q <= req_is_store;
      size_q     <= req_size;
      addr_q     <= req_addr;
      data_q     <= req_data;
    end
  end

  assign req_ready         = ready_q;
  assign trace_write_valid = valid_q;
  assign trace_write_bits  = bits_q;
  assign record_count      = count_q;

endmodule

// File: tb/tb_mem_trace_serializer.sv
// Self-checking bench for mem_trace_serializer: randomized records against a byte-list reference model.
module tb_mem_trace_serializer;

  localparam int unsigned AB = 4;
  localparam int unsigned DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_is_store;
  logic [1:0]    req_size;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic          trace_write_valid;
  logic          trace_write_ready;
  logic [7:0]    trace_write_bits;
  logic [15:0]   record_count;

  int            checks = 0;
  int            passed = 0;
  int            last_wait = 0;
  logic [7:0]    exp_q[$];
  logic [3:0]    model_seq = 4'd0;
  logic [15:0]   model_count = 16'd0;

  mem_trace_serializer #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_is_store      (req_is_store),
    .req_size          (req_size),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .trace_write_valid (trace_write_valid),
    .trace_write_ready (trace_write_ready),
    .trace_write_bits  (trace_write_bits),
    .record_count      (record_count)
  );

  always #5 clock = ~clock;

  // Reference: the byte list a record should produce, from the framing rules.
  function automatic void model_build(bit st, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    int n;
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'(128 + (st ? 64 : 0) + int'(sz) * 16 + int'(model_seq)));
    for (int i = 0; i < int'(AB); i++) exp_q.push_back(8'((a >> (8 * i)) & 32'hFF));
    if (st) begin
      n = 1 << sz;
      if (n > int'(DB)) n = int'(DB);
      for (int i = 0; i < n; i++) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
    end
`ifdef MEMTRACE_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
  endfunction

  // mode 0: sink always ready, 1: random ready, 2: stall 3 cycles on the 2nd address byte
  task automatic send(input bit st, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input int mode);
    int w = 0;
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    bit rdy;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    last_wait = w;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL accept_wait req_ready=%b required 1", req_ready);
    else passed++;
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_addr = a; req_data = d;
    @(negedge clock);
    req_valid = 1'b0;
    req_is_store = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_data = $urandom;
    model_seq = model_seq + 4'd1;
    while (idx < exp_q.size() && cyc < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (idx == 2 && stall < 3) begin rdy = 1'b0; stall++; end
          else rdy = 1'b1;
        end
      endcase
      trace_write_ready = rdy;
      checks++;
      if (trace_write_valid !== 1'b1 || trace_write_bits !== exp_q[idx])
        $display("FAIL byte%0d valid=%b bits=%h required valid=1 bits=%h",
                 idx, trace_write_valid, trace_write_bits, exp_q[idx]);
      else passed++;
      if (rdy) idx++;
      cyc++;
      @(negedge clock);
    end
    if (cyc >= 200) begin
      checks++;
      $display("FAIL record_timeout bytes=%0d required %0d", idx, exp_q.size());
    end
    trace_write_ready = 1'($urandom);
    model_count = model_count + 16'd1;
    checks++;
    if (trace_write_valid !== 1'b0 || req_ready !== 1'b1 || record_count !== model_count)
      $display("FAIL record_end valid=%b ready=%b count=%0d required valid=0 ready=1 count=%0d",
               trace_write_valid, req_ready, record_count, model_count);
    else passed++;
    if (mode == 0) begin
      checks++;
      if (cyc != exp_q.size()) $display("FAIL throughput cycles=%0d required %0d", cyc, exp_q.size());
      else passed++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; trace_write_ready = 1'b0;
    req_is_store = 1'b0; req_size = 2'd0; req_addr = '0; req_data = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (trace_write_valid !== 1'b0 || trace_write_bits !== 8'h00 || record_count !== 16'd0 || req_ready !== 1'b0)
      $display("FAIL reset_values valid=%b bits=%h count=%0d ready=%b required 0 00 0 0",
               trace_write_valid, trace_write_bits, record_count, req_ready);
    else passed++;
    reset = 1'b0;
    model_seq = 4'd0; model_count = 16'd0;
    #1;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL ready_before_edge ready=%b required 0", req_ready);
    else passed++;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_edge ready=%b required 1", req_ready);
    else passed++;
    trace_write_ready = 1'b1;
  endtask

  task automatic test_load_example;
    exp_q = '{8'hA0, 8'h34, 8'h12, 8'h00, 8'h80};
`ifdef MEMTRACE_CHECKSUM_EN
    exp_q.push_back(8'hA0 ^ 8'h34 ^ 8'h12 ^ 8'h00 ^ 8'h80);
`endif
    send(1'b0, 2'd2, 32'h8000_1234, 32'h0, 0);
  endtask

  task automatic test_store_example;
    exp_q = '{8'hD1, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE};
`ifdef MEMTRACE_CHECKSUM_EN
    exp_q.push_back(8'h90);
`endif
    send(1'b1, 2'd1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_backpressure;
    logic [31:0] a;
    logic [31:0] d;
    a = $urandom; d = $urandom;
    model_build(1'b1, 2'd2, a, d);
    send(1'b1, 2'd2, a, d, 2);
  endtask

  task automatic test_size_clamp;
    logic [31:0] a;
    a = $urandom;
    model_build(1'b1, 2'd3, a, 32'h0102_0304);
    send(1'b1, 2'd3, a, 32'h0102_0304, 0);
  endtask

  task automatic test_random;
    bit st;
    logic [1:0] sz;
    logic [31:0] a;
    logic [31:0] d;
    for (int r = 0; r < 20; r++) begin
      st = 1'($urandom); sz = 2'($urandom); a = $urandom; d = $urandom;
      model_build(st, sz, a, d);
      send(st, sz, a, d, 1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    test_reset();
    for (int r = 0; r < 17; r++) begin
      a = $urandom;
      model_build(1'b0, 2'($urandom), a, 32'h0);
      send(1'b0, exp_q[0][5:4], a, 32'h0, 0);
      if (r > 0) begin
        checks++;
        if (last_wait != 0) $display("FAIL idle_gap rec%0d extra_wait=%0d required 0", r, last_wait);
        else passed++;
      end
    end
    checks++;
    if (record_count !== 16'd17) $display("FAIL count17 count=%0d required 17", record_count);
    else passed++;
  endtask

  task automatic test_reset_mid_record;
    logic [31:0] a;
    a = $urandom;
    trace_write_ready = 1'b1;
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_addr = a;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (trace_write_valid !== 1'b0 || record_count !== 16'd0 || req_ready !== 1'b0)
      $display("FAIL mid_reset valid=%b count=%0d ready=%b required 0 0 0",
               trace_write_valid, record_count, req_ready);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    model_seq = 4'd0; model_count = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (trace_write_valid !== 1'b0) $display("FAIL abandoned_byte%0d valid=%b required 0", i, trace_write_valid);
      else passed++;
    end
    a = $urandom;
    model_build(1'b0, 2'd0, a, 32'h0);
    send(1'b0, 2'd0, a, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_load_example();
    test_store_example();
    test_backpressure();
    test_size_clamp();
    test_random();
    test_back_to_back();
    test_reset_mid_record();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
